// File: rtl/serial_dump_pkg.sv
// Shared definitions for the serial memory dump block: state encoding,
// frame geometry and the per-bit tx value helper.
package serial_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_NEXT  = 3'd6
    } state_t;

    localparam int FRAME_BITS           = 10;
    localparam int BYTES_PER_WORD       = 4;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    localparam logic [3:0] STOP_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    // Line level for frame bit bit_idx of byte byte_idx (byte 0 = bits 31:24).
    // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
    function automatic logic frame_bit(input logic [31:0] word,
                                       input logic [1:0]  byte_idx,
                                       input logic [3:0]  bit_idx);
        logic [2:0] data_idx;
        data_idx = 3'(bit_idx - 4'd1);
        if (bit_idx == 4'd0) begin
            return 1'b0;
        end
        if (bit_idx >= STOP_BIT) begin
            return 1'b1;
        end
        return word[{~byte_idx, data_idx}];
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: down-counter that ticks at terminal count zero and
// reloads itself, or is forced back to a full period by restart.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on restart or terminal count, otherwise count down.
    always_comb begin
        cnt_d = cnt_q - ONE;
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/serial_dump.sv
// Streams a block of memory words out of an 8N1 serial line, MSB byte first.
//
// state | meaning
// IDLE  | waiting for start; tx idle high
// FETCH | memRead strobe for the current address
// WAIT  | memory latency; read data captured at the end of this cycle
// START | start bit of the current byte
// DATA  | data bits 1..8 of the current byte, LSB first
// STOP  | stop bit; advances to the next byte or finishes the word
// NEXT  | bump address, decrement remaining count, fetch again or finish
module serial_dump
    import serial_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           baseAddress,
    input  logic [15:0]           wordCount,
    output logic [31:0]           memAddress,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  baud_restart;
    logic                  baud_tick;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock  (clock),
        .reset  (reset),
        .restart(baud_restart),
        .tick   (baud_tick)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        baud_restart = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = baseAddress;
                    remaining_d = wordCount;
                    state_d     = (wordCount == 16'd0) ? ST_NEXT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                shift_d      = memData;
                byte_idx_d   = 2'd0;
                bit_idx_d    = 4'd0;
                baud_restart = 1'b1;
                state_d      = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    bit_idx_d = 4'd1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == STOP_BIT - 4'd1) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    bit_idx_d = 4'd0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_NEXT;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_START;
                    end
                end
            end
            ST_NEXT: begin
                addr_d      = addr_q + 32'd1;
                // A zero-length request lands here with nothing to decrement.
                remaining_d = (remaining_q == 16'd0) ? 16'd0 : remaining_q - 16'd1;
                if (remaining_d != 16'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with it.
        mem_read_d = (state_d == ST_FETCH);
        mem_addr_d = (state_d == ST_FETCH) ? addr_d : mem_addr_q;
        tx_d       = 1'b1;
        if ((state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP)) begin
            tx_d = frame_bit(shift_d[31:0], byte_idx_d, bit_idx_d);
        end
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            remaining_q <= 16'd0;
            shift_q     <= '0;
            bit_idx_q   <= 4'd0;
            byte_idx_q  <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_read_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign memAddress = mem_addr_q;
    assign memRead    = mem_read_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/serial_dump.md
SERIAL_DUMP -- requirements
Module: serial_dump

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory word width (fixed at 32, i.e. 4 bytes per word).
REQ-003 The block SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 The block SHALL have port baseAddress  input  32  first word address, latched on accepted start.
REQ-007 The block SHALL have port wordCount  input  16  number of words to send, latched on accepted start.
REQ-008 The block SHALL have port memAddress  output  32  word address presented to data memory.
REQ-009 The block SHALL have port memRead  output  1  read strobe, one cycle per word.
REQ-010 The block SHALL have port memData  input  32  read data, valid exactly one cycle after memRead.
REQ-011 The block SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-012 The block SHALL have port busy  output  1  high from accepted start until the done cycle, inclusive.
REQ-013 The block SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-014 The state machine SHALL have states IDLE, FETCH, WAIT, START, DATA, STOP and NEXT.
REQ-015 IDLE with start=1 at an edge SHALL latch baseAddress and wordCount and go to FETCH; if latched wordCount=0, it SHALL go to NEXT instead.
REQ-016 FETCH SHALL drive memRead=1 and memAddress=current address for one cycle, then go to WAIT.
REQ-017 WAIT SHALL capture memData into a 32-bit shift word at its end edge, with byte index 0, then go to START.
REQ-018 tx SHALL fall to 0 exactly 3 cycles after the edge that accepted start.
REQ-019 Each word SHALL be sent MSB byte first (bits 31:24 first), each byte LSB first.
REQ-020 Each byte SHALL be framed as 1 start bit (0), 8 data bits, then 1 stop bit (1).
REQ-021 Each frame bit SHALL hold for exactly CLKS_PER_BIT cycles.
REQ-022 The 4 bytes of a word SHALL be sent back-to-back with no idle between stop bit and next start bit.
REQ-023 After the 4th stop bit of a word, the block SHALL go to NEXT.
REQ-024 NEXT SHALL decrement the remaining count and increment the address by 1, wrapping 0xFFFFFFFF to 0x00000000.
REQ-025 From NEXT, the block SHALL go to FETCH if the remaining count is nonzero, otherwise pulse done=1 for one cycle and go to IDLE.
REQ-026 A word therefore SHALL occupy 2 + 40*CLKS_PER_BIT cycles plus 1 NEXT cycle.
REQ-027 wordCount=0 SHALL produce done 2 cycles after the start edge, with no memRead and tx held at 1.
REQ-028 start asserted while busy SHALL be ignored, with no queuing.
REQ-029 start held high continuously SHALL begin a new dump on the first IDLE cycle after done.
REQ-030 Changes to baseAddress or wordCount after acceptance SHALL have no effect.
REQ-031 memRead SHALL be 0 in every state except FETCH.
REQ-032 memAddress SHALL hold the last driven value outside FETCH.
REQ-033 tx SHALL be 1 in IDLE, FETCH, WAIT and NEXT.

Reset
REQ-034 reset=0 SHALL immediately, without a clock edge, force state=IDLE, tx=1, busy=0, done=0, memRead=0, memAddress=0, counters=0 and shift word=0.
REQ-035 Reset mid-frame SHALL abort the dump with no done pulse; a partial byte on tx is acceptable.
REQ-036 After reset release, the first accepted start SHALL behave as a fresh request.

Structure
REQ-037 The state encodings, frame length (10), bytes per word (4) and the CLKS_PER_BIT default SHALL live in the shared processor package.
REQ-038 A single sub-module baud_gen SHALL hold the bit-period down-counter, with a tick output when it reaches terminal count and reload on a restart input.
REQ-039 The bit index counter (0..9) and byte index counter (0..3) SHALL remain in serial_dump.

Verification
REQ-040 With CLKS_PER_BIT=4, base=0x10, count=1 and memData=0x41424344, tx SHALL show bytes 0x41,0x42,0x43,0x44 (0x41 as 0,1,0,0,0,0,0,1,0,1 across the frame), 160 frame cycles, and done once 1 cycle after the last stop bit.
REQ-041 With count=3 and base=0xFFFFFFFF, memRead SHALL hit addresses 0xFFFFFFFF, 0x00000000, 0x00000001, one strobe each, then done.
REQ-042 With count=0, done SHALL pulse 2 cycles after start, with memRead never asserted and tx constantly 1.
REQ-043 A start pulse and a baseAddress change to 0x99 mid-dump SHALL be ignored, with addresses continuing from the original base.
REQ-044 reset=0 asserted during the DATA state of byte 2 SHALL force tx=1 and busy=0 in the same cycle with no done; a new start (base=0x20, count=1) SHALL then complete normally.
REQ-045 With CLKS_PER_BIT=2 and count=2, bit-period accuracy SHALL hold, with a 3-cycle gap of tx=1 (NEXT, FETCH, WAIT) between words.
